// File: rtl/matrix_operand_loader.sv
// Initiator side of the 2x2 multiplier operand handshake. It collects eight serial words,
// pulses Start, then holds both matrices stable until the multiplier acks, or aborts on timeout.
module matrix_operand_loader #(
  parameter int WIDTH       = 32,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             input_Clk,
  input  logic             input_Reset_n,
  input  logic [WIDTH-1:0] input_Word,
  input  logic             input_Word_Valid,
  output logic             output_Word_Ready,
  output logic             output_Start,
  output logic             output_Stable,
  input  logic             input_AB_Ack,
  output logic [WIDTH-1:0] output_A11,
  output logic [WIDTH-1:0] output_A12,
  output logic [WIDTH-1:0] output_A21,
  output logic [WIDTH-1:0] output_A22,
  output logic [WIDTH-1:0] output_B11,
  output logic [WIDTH-1:0] output_B12,
  output logic [WIDTH-1:0] output_B21,
  output logic [WIDTH-1:0] output_B22,
  output logic             output_Busy,
  output logic             output_Error
);

  localparam int NUM_SLOTS = 8;
  localparam int TW        = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                               state_q, state_d;
  logic [2:0]                           count_q, count_d;
  logic [TW-1:0]                        timer_q, timer_d;
  logic                                 err_q, err_d;
  logic                                 accept;
  logic [NUM_SLOTS-1:0][WIDTH-1:0]      slot_q;

  assign output_Word_Ready = (state_q == S_LOAD) && input_Reset_n;
  assign accept            = input_Word_Valid && output_Word_Ready;

  always_ff @(posedge input_Clk) begin
    if (!input_Reset_n) begin
      state_q <= S_LOAD;
      count_q <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    timer_d = timer_q;
    err_d   = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (accept) begin
          if (count_q == 3'd7) begin
            state_d = S_START;
            count_d = '0;
          end else begin
            count_d = count_q + 3'd1;
          end
        end
      end
      S_START: begin
        state_d = S_WAIT;
        timer_d = '0;
      end
      S_WAIT: begin
        // ack takes priority over a timeout landing on the same edge
        if (input_AB_Ack) begin
          state_d = S_LOAD;
          timer_d = '0;
        end else if ((ACK_TIMEOUT != 0) && (timer_q == TMAX)) begin
          state_d = S_LOAD;
          timer_d = '0;
          count_d = '0;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Slot registers only load while in LOAD, so they are frozen whenever Stable is high
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    always_ff @(posedge input_Clk) begin
      if (!input_Reset_n)
        slot_q[i] <= '0;
      else if (accept && (count_q == 3'(i)))
        slot_q[i] <= input_Word;
    end
  end

  assign output_A11    = slot_q[0];
  assign output_A12    = slot_q[1];
  assign output_A21    = slot_q[2];
  assign output_A22    = slot_q[3];
  assign output_B11    = slot_q[4];
  assign output_B12    = slot_q[5];
  assign output_B21    = slot_q[6];
  assign output_B22    = slot_q[7];

  assign output_Start  = (state_q == S_START);
  assign output_Stable = (state_q == S_WAIT);
  assign output_Busy   = (state_q == S_START) || (state_q == S_WAIT);
  assign output_Error  = err_q;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed bench for matrix_operand_loader: reset, nominal load/ack, gapped input,
// backpressure while waiting, ack timeout vs. last-cycle ack, and reset mid-load.
module tb_matrix_operand_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] word;
  logic        valid;
  logic        ready;
  logic        start;
  logic        stable;
  logic        ack;
  logic [31:0] a11, a12, a21, a22, b11, b12, b21, b22;
  logic        busy;
  logic        error;
  logic [7:0][31:0] ab;
  logic [7:0][31:0] e;
  logic [7:0][31:0] fw;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  matrix_operand_loader #(.WIDTH(32), .ACK_TIMEOUT(4)) dut (
    .input_Clk        (clk),
    .input_Reset_n    (rst_n),
    .input_Word       (word),
    .input_Word_Valid (valid),
    .output_Word_Ready(ready),
    .output_Start     (start),
    .output_Stable    (stable),
    .input_AB_Ack     (ack),
    .output_A11       (a11),
    .output_A12       (a12),
    .output_A21       (a21),
    .output_A22       (a22),
    .output_B11       (b11),
    .output_B12       (b12),
    .output_B21       (b21),
    .output_B22       (b22),
    .output_Busy      (busy),
    .output_Error     (error)
  );

  assign ab = {b22, b21, b12, b11, a22, a21, a12, a11};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ab(input string tag, input logic [7:0][31:0] ex);
    for (int i = 0; i < 8; i++) chk($sformatf("%s[%0d]", tag, i), ab[i], ex[i]);
  endtask

  task automatic load8(input logic [31:0] base);
    for (int i = 0; i < 8; i++) begin
      valid = 1'b1;
      word  = base + 32'(i);
      step();
    end
    valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; valid = 1'b0; word = '0; ack = 1'b0;

    // T1 reset
    repeat (3) step();
    chk("rst_ready", ready, 0);
    chk("rst_start", start, 0);
    chk("rst_stable", stable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk_ab("rst_ab", '0);
    rst_n = 1'b1; #1;
    chk("rel_ready", ready, 1);

    // T2 nominal stream 1..8
    load8(32'd1);
    for (int i = 0; i < 8; i++) e[i] = 32'(i + 1);
    chk("nom_start", start, 1);
    chk("nom_stable0", stable, 0);
    chk("nom_busy", busy, 1);
    chk("nom_ready0", ready, 0);
    chk_ab("nom_ab", e);
    step();
    chk("nom_start_drop", start, 0);
    chk("nom_stable1", stable, 1);
    step(); step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("nom_ack_stable", stable, 0);
    chk("nom_ack_ready", ready, 1);
    chk("nom_ack_error", error, 0);
    chk("nom_ack_busy", busy, 0);

    // T3 gapped valid, float words 1.0 .. 8.0
    fw[0] = 32'h3F800000; fw[1] = 32'h40000000; fw[2] = 32'h40400000; fw[3] = 32'h40800000;
    fw[4] = 32'h40A00000; fw[5] = 32'h40C00000; fw[6] = 32'h40E00000; fw[7] = 32'h41000000;
    for (int i = 0; i < 16; i++) begin
      valid = (i % 2 == 0);
      word  = valid ? fw[i/2] : 32'hBAD00000 + 32'(i);
      step();
      if (i < 15) chk($sformatf("gap_start%0d", i), start, 32'(i == 14));
    end
    chk("gap_stable", stable, 1);
    chk_ab("gap_ab", fw);

    // T4 valid held while waiting for ack
    valid = 1'b1; word = 32'h0000DEAD;
    step(); step();
    chk("bp_ready", ready, 0);
    chk("bp_stable", stable, 1);
    chk_ab("bp_ab", fw);
    ack = 1'b1; valid = 1'b0;
    step();
    ack = 1'b0;
    chk("bp_ack_stable", stable, 0);
    chk_ab("bp_after_ab", fw);

    // T5 ack timeout after 4 stable cycles
    load8(32'h10000000);
    for (int i = 0; i < 8; i++) e[i] = 32'h10000000 + 32'(i);
    chk("to_start", start, 1);
    for (int s = 0; s < 4; s++) begin
      step();
      chk($sformatf("to_stable%0d", s), stable, 1);
      chk($sformatf("to_noerr%0d", s), error, 0);
    end
    step();
    chk("to_error", error, 1);
    chk("to_stable_drop", stable, 0);
    chk("to_ready", ready, 1);
    chk("to_busy", busy, 0);
    step();
    chk("to_error_pulse", error, 0);
    chk_ab("to_ab_kept", e);

    // T5b ack on the last permitted cycle beats the timeout
    load8(32'h20000000);
    for (int i = 0; i < 8; i++) e[i] = 32'h20000000 + 32'(i);
    chk("lk_start", start, 1);
    for (int s = 0; s < 4; s++) begin
      step();
      chk($sformatf("lk_stable%0d", s), stable, 1);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("lk_error", error, 0);
    chk("lk_stable_drop", stable, 0);
    chk("lk_ready", ready, 1);
    step();
    chk("lk_error_after", error, 0);
    chk_ab("lk_ab", e);

    // ack while loading is ignored
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("idle_ack_busy", busy, 0);
    chk("idle_ack_ready", ready, 1);

    // T6 reset after 5 words, then a fresh full load
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1; word = 32'h55000000 + 32'(i);
      step();
    end
    valid = 1'b0;
    rst_n = 1'b0;
    step();
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk_ab("mid_rst_ab", '0);
    rst_n = 1'b1;
    load8(32'h60000000);
    for (int i = 0; i < 8; i++) e[i] = 32'h60000000 + 32'(i);
    chk("mid_start", start, 1);
    chk_ab("mid_ab", e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
